if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the fetch PC register and produces id_pc; drives read addresses to the synchronous BIOS and IMEM instruction memories so their outputs line up with id_pc one cycle later.
- Applies redirects from decode (jal/jalr/predicted branch) and execute (flush/mispredict), and honours decode stalls.
- Flags misaligned redirect targets and keeps fetch/cycle counters for performance CSRs.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset (BIOS region, bit 30 set).
- BIOS_AW, 12, BIOS word-address width.
- IMEM_AW, 14, IMEM word-address width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ex_flush  input  1  EX redirect (mispredict/jump resolved in EX)
- ex_target  input  32  EX redirect target
- id_stall  input  1  decode hazard stall
- id_target  input  32  decode-generated target
- id_target_taken  input  1  use id_target as next PC
- bios_addr  output  BIOS_AW  BIOS read word address (combinational from next_pc)
- imem_addr  output  IMEM_AW  IMEM read word address (combinational from next_pc)
- id_pc  output  32  PC of the instruction presented to decode
- id_valid  output  1  memory output at id_pc is a real instruction
- fetch_fault  output  1  misaligned redirect captured
- cycle_cnt  output  32  cycles since reset
- fetch_cnt  output  32  instructions accepted by decode

Behaviour:
- Reset is asynchronous. While rst is high: state=BOOT, id_pc=RESET_PC, id_valid=0, fetch_fault=0, both counters=0, next_pc=RESET_PC.
- Address outputs:
  - bios_addr = next_pc[BIOS_AW+1:2]; imem_addr = next_pc[IMEM_AW+1:2].
  - Both are driven every cycle. Region selection is downstream, via id_pc[30].
- States:
  - BOOT: one cycle after reset release. id_valid=0. next_pc=RESET_PC. Go to RUN. ex_flush and id_target_taken are ignored.
  - RUN: id_valid=1. next_pc priority:
    - (1) ex_flush -> ex_target
    - (2) id_stall -> id_pc (re-read the same word; the memory output must hold)
    - (3) id_target_taken -> id_target
    - (4) id_pc+4, 32-bit wrap
    - id_target_taken while id_stall is ignored; decode re-asserts it when the stall clears.
  - FAULT: entered from RUN when the selected redirect target (ex_target under ex_flush, or id_target under case 3) has bits [1:0] != 0.
    - Registered on the transition edge: id_pc = offending target; fetch_fault=1.
    - id_valid=0 in FAULT. next_pc=id_pc (hold).
    - Leave only on ex_flush with aligned ex_target: go to RUN, id_pc=ex_target, fetch_fault=0.
    - ex_flush with a misaligned target in FAULT: stay, update id_pc.
- id_pc register: id_pc <= next_pc every cycle, except as overridden in FAULT.
- Counters:
  - cycle_cnt increments every cycle after reset release (including BOOT and FAULT) and wraps at 2^32.
  - fetch_cnt increments when id_valid & ~id_stall & ~ex_flush, and wraps.
- Simultaneous events:
  - ex_flush overrides id_stall and id_target_taken in the same cycle.
  - rst overrides everything, in any state, asynchronously.
- Latency: a redirect in cycle N changes the memory address in cycle N and id_pc at edge N+1. There is no extra bubble.

Test Plan:
- Reset, RESET_PC=0x4000_0000: release rst -> one BOOT cycle with id_valid=0 and bios_addr=0x000; then id_pc=0x4000_0000, 0x4000_0004, 0x4000_0008 on successive cycles; fetch_cnt=2 after the third RUN cycle.
- id_stall held 3 cycles at id_pc=0x4000_0010 -> id_pc and bios_addr stay constant (0x4000_0010 / 0x004); fetch_cnt frozen; cycle_cnt still advances by 3.
- id_target_taken with id_target=0x1000_0100 -> next cycle id_pc=0x1000_0100 and imem_addr=0x040. Same pulse with id_stall=1 -> id_pc unchanged.
- ex_flush=1, ex_target=0x0000_0200, with id_stall=1 and id_target_taken=1 simultaneously -> next id_pc=0x0000_0200; fetch_cnt not incremented.
- id_target_taken with id_target=0x0000_0102 -> FAULT: fetch_fault=1, id_valid=0, id_pc=0x0000_0102 held. Then ex_flush to 0x0000_0300 -> RUN, id_pc=0x0000_0300, fetch_fault=0.
- Assert rst mid-RUN at id_pc=0x0000_0040 -> outputs return to reset values immediately, without waiting for a clock edge; after release, BOOT is seen again.

Source files
------------

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage: fetch PC, redirects, stalls, fault
//            capture and fetch/cycle counters.
// Revision : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int          BIOS_AW  = 12,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_flush,
    input  logic [31:0]        ex_target,
    input  logic               id_stall,
    input  logic [31:0]        id_target,
    input  logic               id_target_taken,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        id_pc,
    output logic               id_valid,
    output logic               fetch_fault,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] next_pc;

    always_comb begin
        state_d       = state_q;
        next_pc       = id_pc_q;
        fetch_fault_d = fetch_fault_q;
        case (state_q)
            ST_BOOT: begin
                next_pc = RESET_PC;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ex_flush) begin
                    next_pc = ex_target;
                    if (ex_target[1:0] != 2'b00) begin
                        state_d       = ST_FAULT;
                        fetch_fault_d = 1'b1;
                    end
                end else if (id_stall) begin
                    next_pc = id_pc_q;
                end else if (id_target_taken) begin
                    next_pc = id_target;
                    if (id_target[1:0] != 2'b00) begin
                        state_d       = ST_FAULT;
                        fetch_fault_d = 1'b1;
                    end
                end else begin
                    next_pc = id_pc_q + 32'd4;
                end
            end
            ST_FAULT: begin
                // Only an EX redirect can recover; a misaligned one just re-captures.
                if (ex_flush) begin
                    next_pc = ex_target;
                    if (ex_target[1:0] == 2'b00) begin
                        state_d       = ST_RUN;
                        fetch_fault_d = 1'b0;
                    end
                end
            end
            default: begin
                next_pc = RESET_PC;
                state_d = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        id_pc_d     = next_pc;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        fetch_cnt_d = fetch_cnt_q;
        if ((state_q == ST_RUN) && !id_stall && !ex_flush) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            id_pc_q       <= RESET_PC;
            fetch_fault_q <= 1'b0;
            cycle_cnt_q   <= 32'd0;
            fetch_cnt_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            id_pc_q       <= id_pc_d;
            fetch_fault_q <= fetch_fault_d;
            cycle_cnt_q   <= cycle_cnt_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end

    assign bios_addr   = next_pc[BIOS_AW+1:2];
    assign imem_addr   = next_pc[IMEM_AW+1:2];
    assign id_pc       = id_pc_q;
    assign id_valid    = (state_q == ST_RUN);
    assign fetch_fault = fetch_fault_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign fetch_cnt   = fetch_cnt_q;

endmodule
`default_nettype wire
